ldpc_rx_fifo: RTL and testbench
===============================

# ldpc_rx_fifo

Receive-side buffer directly downstream of the UART/LDPC receive and decode path. It captures each decoded byte (`message`) together with its error status (`syndrome` non-zero) when the decoder signals `rx_done`. Captured frames are held in a first-word-fall-through FIFO, and the consumer drains them through a valid/ready handshake. Optional frame and error counters give link-quality statistics.

## Interface
- `DEPTH`, 8, number of FIFO entries; power of two, ≥2.
- `AW`, 3, pointer width; must equal log2(`DEPTH`).

Ports (name, direction, width, meaning):
- `clk` input 1: system clock; all state changes on the rising edge.
- `rst` input 1: reset, asynchronous, active-low (0 = reset).
- `rx_done` input 1: decoder completion; may be held high for many cycles. Only its rising edge captures a frame.
- `message` input 8: decoded byte; valid while `rx_done` is high.
- `syndrome` input 8: decoder syndrome for the frame; non-zero means an error was detected.
- `out_valid` output 1: head entry available.
- `out_ready` input 1: consumer accepts the head entry.
- `out_data` output 8: head entry byte.
- `out_err` output 1: head entry error flag (captured `|syndrome`).
- `level` output AW+1: number of stored entries, 0..`DEPTH`.
- `full` output 1: `level` == `DEPTH`.
- `empty` output 1: `level` == 0.
- `overflow` output 1: sticky; set when a frame is dropped because the FIFO is full.
- `clr_stats` input 1: synchronous clear of `overflow`, `frame_cnt` and `err_cnt`.
- `frame_cnt` output 16: frames seen, saturating.
- `err_cnt` output 16: frames with non-zero syndrome, saturating.

## Operation
- Edge detect: register `rx_done_q`. Capture event when `rx_done & ~rx_done_q`.
- Storage: register array of `DEPTH` × 9 bits holding {err, data}.
  - `wr_ptr` and `rd_ptr` are AW bits and wrap modulo `DEPTH`.
  - `level` is a separate AW+1-bit counter.
- Push: on a capture event, if not full, or if full with a pop in the same cycle:
  - write {`|syndrome`, `message`} at `wr_ptr`;
  - `wr_ptr` increments.
- Pop: when `out_valid & out_ready`, `rd_ptr` increments.
- Level update: `level` +1 on push only, −1 on pop only, unchanged on push+pop.
- Drop: a capture event while full with no pop stores nothing and sets `overflow`.
- Outputs:
  - `out_valid` = ~`empty`.
  - `out_data` / `out_err` = `mem[rd_ptr]`, combinational from the register array.
  - While empty, `out_data` / `out_err` are don't-care; the bench must not check them.
- Statistics, on every capture event including dropped frames:
  - `frame_cnt` +1;
  - `err_cnt` +1 if `syndrome` != 0;
  - both saturate at 16'hFFFF.
- `clr_stats` has priority over a same-cycle increment or overflow set: the result is 0.
- FIFO contents and pointers are unaffected by `clr_stats`.

## Timing
- Reset values:
  - `out_valid`=0, `empty`=1, `full`=0, `level`=0, `overflow`=0;
  - `frame_cnt`=0, `err_cnt`=0;
  - pointers 0; `out_data`/`out_err` don't-care.
- `rx_done_q` resets to 1, so an `rx_done` held high across reset release produces no capture. The first capture requires `rx_done` to go low, then high.
- Latency: with `rx_done` sampled 1 at edge N after being 0 at edge N−1:
  - entry written at edge N;
  - `out_valid`, `level` and counters update after edge N.
- Pop takes effect at the edge where `out_valid & out_ready` is sampled. The next entry appears immediately after that edge.
- One capture per `rx_done` rising edge; back-to-back capture events need `rx_done` low for ≥1 cycle between them.
- Reset asserted mid-operation clears all state immediately; buffered frames are lost.

## Configuration
- `LDPC_RXF_STATS_EN`
  - Defined: `frame_cnt`, `err_cnt` and their saturation/clear logic are compiled in as described.
  - Undefined: counter registers are omitted and `frame_cnt`/`err_cnt` are tied to 16'h0000. `overflow` and `clr_stats` remain functional in both builds.

## Test plan
- Reset with `rx_done` held 1, release, hold 20 cycles → `empty`=1, `level`=0, no capture, counters 0.
- Three pulses: `message`=8'hDD/8'h55/8'hA3 with `syndrome`=0/8'h1C/0, `out_ready`=0 → `level`=3. Then set `out_ready`=1 → outputs in order DD/err0, 55/err1, A3/err0; `frame_cnt`=3, `err_cnt`=1.
- Fill 8 entries, ninth pulse with `out_ready`=0 → ninth dropped, `overflow`=1, `level`=8, `frame_cnt`=9. Drain → the 8 original bytes in order; `overflow` stays 1 until `clr_stats`.
- FIFO full, capture event and pop in the same cycle → `level` stays 8, no overflow, new byte emerges last. Continue 20 frames → correct order across pointer wrap.
- `clr_stats` coinciding with an error capture → `frame_cnt`=0, `err_cnt`=0, `overflow`=0, entry still stored. Preload counters near 16'hFFFE, apply 3 events → saturate at 16'hFFFF.
- Assert `rst` low with 5 entries buffered → outputs return to reset values the same cycle, without waiting for `clk`.

Source files
------------

// File: rtl/ldpc_rx_fifo.sv
// Receive-side FWFT buffer for decoded LDPC bytes with error flag, valid/ready drain.
// Define LDPC_RXF_STATS_EN to compile in the saturating frame/error counters.
module ldpc_rx_fifo #(
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          rx_done,
    input  logic [7:0]    message,
    input  logic [7:0]    syndrome,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [7:0]    out_data,
    output logic          out_err,
    output logic [AW:0]   level,
    output logic          full,
    output logic          empty,
    output logic          overflow,
    input  logic          clr_stats,
    output logic [15:0]   frame_cnt,
    output logic [15:0]   err_cnt
);

    localparam logic [AW:0]   LVL_FULL = (AW + 1)'(DEPTH);
    localparam logic [AW:0]   LVL_ONE  = (AW + 1)'(1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    logic          rx_done_q;
    logic [8:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   level_q;
    logic          overflow_q;
    logic          capture;
    logic          pop;
    logic          push;
    logic          drop;
    logic          syn_err;

    assign syn_err   = |syndrome;
    assign capture   = rx_done & ~rx_done_q;
    assign full      = (level_q == LVL_FULL);
    assign empty     = (level_q == '0);
    assign out_valid = ~empty;
    assign pop       = out_valid & out_ready;
    // A full FIFO still accepts a frame when the head leaves in the same cycle.
    assign push      = capture & (~full | pop);
    assign drop      = capture & full & ~pop;

    assign level     = level_q;
    assign overflow  = overflow_q;
    assign out_data  = mem[rd_ptr][7:0];
    assign out_err   = mem[rd_ptr][8];

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {syn_err, message};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_done_q  <= 1'b1;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            level_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            rx_done_q <= rx_done;
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            if (push && !pop) begin
                level_q <= level_q + LVL_ONE;
            end else if (pop && !push) begin
                level_q <= level_q - LVL_ONE;
            end
            if (clr_stats) begin
                overflow_q <= 1'b0;
            end else if (drop) begin
                overflow_q <= 1'b1;
            end
        end
    end

`ifdef LDPC_RXF_STATS_EN
    logic [15:0] frame_cnt_q;
    logic [15:0] err_cnt_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            frame_cnt_q <= '0;
            err_cnt_q   <= '0;
        end else if (clr_stats) begin
            frame_cnt_q <= '0;
            err_cnt_q   <= '0;
        end else if (capture) begin
            if (frame_cnt_q != 16'hFFFF) begin
                frame_cnt_q <= frame_cnt_q + 16'd1;
            end
            if (syn_err && (err_cnt_q != 16'hFFFF)) begin
                err_cnt_q <= err_cnt_q + 16'd1;
            end
        end
    end

    assign frame_cnt = frame_cnt_q;
    assign err_cnt   = err_cnt_q;
`else
    assign frame_cnt = 16'h0000;
    assign err_cnt   = 16'h0000;
`endif

endmodule

// File: tb/tb_ldpc_rx_fifo.sv
// Bench for ldpc_rx_fifo: queue-based reference model checked every cycle, plus literal
// spot checks for the directed scenarios.
module tb_ldpc_rx_fifo;

    localparam int DEPTH = 8;
    localparam int AW    = 3;
`ifdef LDPC_RXF_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          rx_done = 1'b1;
    logic [7:0]    message = 8'h00;
    logic [7:0]    syndrome = 8'h00;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [7:0]    out_data;
    logic          out_err;
    logic [AW:0]   level;
    logic          full;
    logic          empty;
    logic          overflow;
    logic          clr_stats = 1'b0;
    logic [15:0]   frame_cnt;
    logic [15:0]   err_cnt;

    ldpc_rx_fifo #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk(clk), .rst(rst), .rx_done(rx_done), .message(message), .syndrome(syndrome),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_err(out_err),
        .level(level), .full(full), .empty(empty), .overflow(overflow),
        .clr_stats(clr_stats), .frame_cnt(frame_cnt), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: a queue of {err,data} plus plain counters.
    logic [8:0] mq[$];
    logic [8:0] popped[$];
    bit         m_prev = 1'b1;
    bit         m_ovf = 1'b0;
    int         m_fc = 0;
    int         m_ec = 0;
    int         preload_seq = 0;
    int         preload_seen = 0;

    initial forever begin
        @(posedge clk or negedge rst);
        if (!rst) begin
            mq.delete();
            m_prev = 1'b1;
            m_ovf  = 1'b0;
            m_fc   = 0;
            m_ec   = 0;
        end else begin
            bit cap, pop, was_full;
            cap      = rx_done && !m_prev;
            m_prev   = rx_done;
            pop      = (mq.size() > 0) && out_ready;
            was_full = (mq.size() == DEPTH);
            if (preload_seq != preload_seen) begin
                preload_seen = preload_seq;
                m_fc = 16'hFFFE;
                m_ec = 16'hFFFE;
            end
            if (pop) void'(mq.pop_front());
            if (cap && (!was_full || pop)) mq.push_back({|syndrome, message});
            if (clr_stats) begin
                m_ovf = 1'b0;
                m_fc  = 0;
                m_ec  = 0;
            end else if (cap) begin
                if (was_full && !pop) m_ovf = 1'b1;
                if (m_fc < 65535) m_fc++;
                if (syndrome != 0 && m_ec < 65535) m_ec++;
            end
        end
    end

    initial forever begin
        @(negedge clk);
        if (rst) begin
            chk("level", int'(level), mq.size());
            chk("empty", int'(empty), int'(mq.size() == 0));
            chk("full", int'(full), int'(mq.size() == DEPTH));
            chk("out_valid", int'(out_valid), int'(mq.size() > 0));
            chk("overflow", int'(overflow), int'(m_ovf));
            chk("frame_cnt", int'(frame_cnt), STATS ? m_fc : 0);
            chk("err_cnt", int'(err_cnt), STATS ? m_ec : 0);
            if (mq.size() > 0) chk("head", int'({out_err, out_data}), int'(mq[0]));
            if (out_valid && out_ready) popped.push_back({out_err, out_data});
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse(input logic [7:0] msg, input logic [7:0] syn);
        @(posedge clk); #1;
        rx_done = 1'b1; message = msg; syndrome = syn;
        @(posedge clk); #1;
        rx_done = 1'b0;
    endtask

    int base;

    initial begin
        // Reset with rx_done held high across release: no capture.
        #23 rst = 1'b1;
        cycles(20);
        chk("hold_level", int'(level), 0);
        chk("hold_empty", int'(empty), 1);
        chk("hold_frames", int'(frame_cnt), 0);
        rx_done = 1'b0;
        cycles(2);

        // Three frames buffered, then drained in order.
        pulse(8'hDD, 8'h00);
        pulse(8'h55, 8'h1C);
        pulse(8'hA3, 8'h00);
        cycles(2);
        chk("three_level", int'(level), 3);
        base = popped.size();
        out_ready = 1'b1;
        cycles(5);
        chk("three_pop0", int'(popped[base]), 9'h0DD);
        chk("three_pop1", int'(popped[base+1]), 9'h155);
        chk("three_pop2", int'(popped[base+2]), 9'h0A3);
        chk("three_frames", int'(frame_cnt), STATS ? 3 : 0);
        chk("three_errs", int'(err_cnt), STATS ? 1 : 0);

        // Fill, drop the ninth, drain; overflow sticky until cleared.
        out_ready = 1'b0;
        for (int i = 0; i < 8; i++) pulse(8'(i * 17 + 1), i[0] ? 8'h01 : 8'h00);
        pulse(8'hEE, 8'h00);
        cycles(2);
        chk("fill_level", int'(level), 8);
        chk("fill_ovf", int'(overflow), 1);
        chk("fill_frames", int'(frame_cnt), STATS ? 12 : 0);
        chk("fill_errs", int'(err_cnt), STATS ? 5 : 0);
        base = popped.size();
        out_ready = 1'b1;
        cycles(10);
        for (int i = 0; i < 8; i++)
            chk("fill_order", int'(popped[base+i]), int'({i[0], 8'(i * 17 + 1)}));
        chk("fill_ovf_sticky", int'(overflow), 1);
        clr_stats = 1'b1;
        cycles(1);
        clr_stats = 1'b0;
        chk("clr_ovf", int'(overflow), 0);

        // Full with simultaneous capture and pop.
        out_ready = 1'b0;
        for (int i = 0; i < 8; i++) pulse(8'h10 + 8'(i), 8'h00);
        cycles(1);
        base = popped.size();
        rx_done = 1'b1; message = 8'hC7; syndrome = 8'h00; out_ready = 1'b1;
        cycles(1);
        rx_done = 1'b0; out_ready = 1'b0;
        chk("pp_level", int'(level), 8);
        chk("pp_ovf", int'(overflow), 0);
        out_ready = 1'b1;
        cycles(12);
        chk("pp_first", int'(popped[base]), 9'h010);
        chk("pp_last", int'(popped[base+8]), 9'h0C7);
        for (int i = 0; i < 20; i++) begin
            out_ready = 1'($urandom_range(0, 1));
            pulse(8'($urandom), 8'($urandom_range(0, 1) * $urandom_range(1, 255)));
        end
        out_ready = 1'b1;
        cycles(12);

        // clr_stats wins over a same-cycle error capture; entry is still stored.
        out_ready = 1'b0;
        rx_done = 1'b1; message = 8'h3C; syndrome = 8'h80; clr_stats = 1'b1;
        cycles(1);
        rx_done = 1'b0; clr_stats = 1'b0;
        chk("clr_frames", int'(frame_cnt), 0);
        chk("clr_errs", int'(err_cnt), 0);
        chk("clr_level", int'(level), 1);
        chk("clr_head", int'({out_err, out_data}), 9'h13C);

`ifdef LDPC_RXF_STATS_EN
        @(negedge clk); #1;
        force dut.frame_cnt_q = 16'hFFFE;
        force dut.err_cnt_q = 16'hFFFE;
        preload_seq++;
        #1;
        release dut.frame_cnt_q;
        release dut.err_cnt_q;
`endif
        for (int i = 0; i < 3; i++) pulse(8'h70 + 8'(i), 8'h05);
        cycles(1);
        chk("sat_frames", int'(frame_cnt), STATS ? 16'hFFFF : 0);
        chk("sat_errs", int'(err_cnt), STATS ? 16'hFFFF : 0);
        out_ready = 1'b1;
        cycles(8);

        // Random traffic.
        for (int i = 0; i < 600; i++) begin
            rx_done   = 1'($urandom_range(0, 1));
            message   = 8'($urandom);
            syndrome  = ($urandom_range(0, 1) == 1) ? 8'($urandom) : 8'h00;
            out_ready = ($urandom_range(0, 3) != 0) ? (i % 200 > 60) : 1'b0;
            clr_stats = ($urandom_range(0, 29) == 0);
            cycles(1);
        end
        clr_stats = 1'b0; rx_done = 1'b0;

        // Asynchronous reset with frames buffered.
        out_ready = 1'b0;
        cycles(2);
        while (level > 0 && n_cmp < 100000) begin
            out_ready = 1'b1;
            cycles(1);
        end
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) pulse(8'h40 + 8'(i), 8'h02);
        cycles(1);
        chk("prerst_level", int'(level), 5);
        #3 rst = 1'b0;
        #1;
        chk("rst_level", int'(level), 0);
        chk("rst_empty", int'(empty), 1);
        chk("rst_valid", int'(out_valid), 0);
        chk("rst_full", int'(full), 0);
        chk("rst_ovf", int'(overflow), 0);
        chk("rst_frames", int'(frame_cnt), 0);
        chk("rst_errs", int'(err_cnt), 0);
        cycles(2);
        rst = 1'b1;
        cycles(3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
